// File: rtl/flit_unpacker.sv
// Reassembles a compressed flit (header beat + 0..8 payload beats of 16 bits)
// into a zero-filled 128-bit flit presented on a valid/ready output.
module flit_unpacker #(
    parameter int FLIT_WIDTH = 128,
    parameter int BEAT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BEAT_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [FLIT_WIDTH-1:0] out_flit,
    output logic [2:0]            out_en,
    output logic [7:0]            out_len,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  hdr_err,
    output logic [15:0]           flit_cnt
);

    localparam int MAX_BEATS = FLIT_WIDTH / BEAT_WIDTH;
    localparam int IDX_W     = $clog2(MAX_BEATS);
    localparam int BASE_W    = $clog2(FLIT_WIDTH);
    localparam int SHIFT_W   = $clog2(BEAT_WIDTH);

    typedef enum logic [1:0] {
        S_HDR,
        S_PAY,
        S_OUT
    } state_t;

    state_t                state_q, state_d;
    logic [FLIT_WIDTH-1:0] flit_q;
    logic [2:0]            en_q;
    logic [7:0]            len_q;
    logic [IDX_W:0]        beats_q;
    logic [IDX_W-1:0]      idx_q;
    logic                  hdr_err_q;
    logic [15:0]           cnt_q;

    logic [2:0]            hdr_en;
    logic [7:0]            hdr_len;
    logic [IDX_W:0]        hdr_beats;
    logic                  last_beat;
    logic [BASE_W-1:0]     beat_base;

    // en=001 is the full-width flit; every other code maps to en*16 bits.
    assign hdr_en    = in_data[2:0];
    assign hdr_len   = (hdr_en == 3'b001) ? 8'd128 : {1'b0, hdr_en, 4'b0000};
    assign hdr_beats = (hdr_en == 3'b001) ? 4'd8 : {1'b0, hdr_en};
    assign last_beat = ({1'b0, idx_q} == beats_q - 4'd1);
    assign beat_base = {idx_q, {SHIFT_W{1'b0}}};

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            S_HDR: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = (hdr_beats == '0) ? S_OUT : S_PAY;
                end
            end
            S_PAY: begin
                in_ready = 1'b1;
                if (in_valid && last_beat) begin
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = S_HDR;
                end
            end
            default: state_d = S_HDR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_HDR;
            flit_q    <= '0;
            en_q      <= '0;
            len_q     <= '0;
            beats_q   <= '0;
            idx_q     <= '0;
            hdr_err_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            hdr_err_q <= 1'b0;
            case (state_q)
                S_HDR: begin
                    if (in_valid) begin
                        en_q      <= hdr_en;
                        len_q     <= hdr_len;
                        beats_q   <= hdr_beats;
                        flit_q    <= '0;
                        idx_q     <= '0;
                        // The header is still decoded even with reserved bits set.
                        hdr_err_q <= |in_data[BEAT_WIDTH-1:3];
                    end
                end
                S_PAY: begin
                    if (in_valid) begin
                        flit_q[beat_base +: BEAT_WIDTH] <= in_data;
                        idx_q <= idx_q + 1'b1;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_flit = flit_q;
    assign out_en   = en_q;
    assign out_len  = len_q;
    assign hdr_err  = hdr_err_q;
    assign flit_cnt = cnt_q;

endmodule

// File: tb/tb_flit_unpacker.sv
// Directed bench for flit_unpacker: vector table of single flits plus
// hand-written reset, backpressure and counter-wrap sequences.
module tb_flit_unpacker;

    logic         clk = 1'b0;
    logic         rst;
    logic [15:0]  in_data;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] out_flit;
    logic [2:0]   out_en;
    logic [7:0]   out_len;
    logic         out_valid;
    logic         out_ready;
    logic         hdr_err;
    logic [15:0]  flit_cnt;

    int checks   = 0;
    int failures = 0;
    logic [15:0] cnt_exp;

    typedef struct {
        logic [15:0]         hdr;
        logic [7:0][15:0]    beat;
        int                  nbeats;
        logic [7:0]          len;
        logic [127:0]        flit;
        logic                err;
    } vec_t;

    vec_t tbl [8];
    vec_t v_tmp;

    flit_unpacker dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_flit  (out_flit),
        .out_en    (out_en),
        .out_len   (out_len),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .hdr_err   (hdr_err),
        .flit_cnt  (flit_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [15:0] hdr, input logic [127:0] beats,
                                input int n, input logic [7:0] len,
                                input logic [127:0] flit, input logic err);
        vec_t v;
        v.hdr    = hdr;
        v.beat   = beats;
        v.nbeats = n;
        v.len    = len;
        v.flit   = flit;
        v.err    = err;
        return v;
    endfunction

    // Sends one flit with random in_valid gaps, checks it, then hands it off.
    // hold > 0 keeps out_ready low that many cycles with a zero-length header pending.
    task automatic run_vec(input vec_t v, input int hold);
        int   acc;
        int   cyc;
        int   k;
        logic will;
        logic extra;
        @(negedge clk);
        chk("hdr_in_ready", in_ready, 1);
        in_valid  = 1'b1;
        in_data   = v.hdr;
        out_ready = 1'b1;
        @(negedge clk);
        chk("hdr_err", hdr_err, v.err);
        acc = 0; cyc = 0; k = 0; extra = 1'b0;
        while (!out_valid && cyc < 60) begin
            in_valid = ($urandom_range(0, 2) != 0);
            in_data  = in_valid ? ((k < 8) ? v.beat[k] : 16'hBAD0) : 16'($urandom);
            will     = in_valid && in_ready;
            @(negedge clk);
            if (hdr_err) extra = 1'b1;
            if (will) begin
                acc++;
                k++;
            end
            cyc++;
        end
        in_valid = 1'b0;
        chk("out_valid_timeout", out_valid, 1);
        chk("hdr_err_pulse_len", extra, 0);
        chk("out_in_ready", in_ready, 0);
        chk("out_flit", out_flit, v.flit);
        chk("out_len", out_len, v.len);
        chk("out_en", out_en, v.hdr[2:0]);
        chk("beats_consumed", acc, v.nbeats);
        chk("cnt_before", flit_cnt, cnt_exp);
        if (hold > 0) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_data   = 16'h0000;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                chk("bp_in_ready", in_ready, 0);
                chk("bp_out_valid", out_valid, 1);
                chk("bp_flit", out_flit, v.flit);
                chk("bp_len", out_len, v.len);
                chk("bp_cnt", flit_cnt, cnt_exp);
            end
            out_ready = 1'b1;
        end
        @(negedge clk);
        cnt_exp = cnt_exp + 16'd1;
        chk("post_out_valid", out_valid, 0);
        chk("post_in_ready", in_ready, 1);
        chk("post_cnt", flit_cnt, cnt_exp);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = mk(16'h0001, 128'h0008_0007_0006_0005_0004_0003_0002_0001, 8, 8'd128,
                    128'h0008_0007_0006_0005_0004_0003_0002_0001, 1'b0);
        tbl[1] = mk(16'h0003, 128'hEEEE_EEEE_EEEE_EEEE_EEEE_3333_2222_1111, 3, 8'd48,
                    128'h3333_2222_1111, 1'b0);
        tbl[2] = mk(16'h0000, 128'hEEEE_EEEE_EEEE_EEEE_EEEE_EEEE_EEEE_EEEE, 0, 8'd0,
                    128'h0, 1'b0);
        tbl[3] = mk(16'h0005, 128'hEEEE_EEEE_EEEE_1abc_0789_e5f6_c3d4_a1b2, 5, 8'd80,
                    128'h1abc_0789_e5f6_c3d4_a1b2, 1'b0);
        tbl[4] = mk(16'h0006, 128'hEEEE_EEEE_5678_1234_f00d_cafe_beef_dead, 6, 8'd96,
                    128'h5678_1234_f00d_cafe_beef_dead, 1'b0);
        tbl[5] = mk(16'h0007, 128'hEEEE_ccdd_aabb_8899_6677_4455_2233_0011, 7, 8'd112,
                    128'hccdd_aabb_8899_6677_4455_2233_0011, 1'b0);
        tbl[6] = mk(16'h0004, 128'hEEEE_EEEE_EEEE_EEEE_ffff_ffff_ffff_ffff, 4, 8'd64,
                    128'hffff_ffff_ffff_ffff, 1'b0);
        tbl[7] = mk(16'hFFFA, 128'hEEEE_EEEE_EEEE_EEEE_EEEE_EEEE_2468_1357, 2, 8'd32,
                    128'h2468_1357, 1'b1);

        rst = 1'b1; in_valid = 1'b0; in_data = 16'h0; out_ready = 1'b1;
        cnt_exp = 16'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_flit", out_flit, 0);
        chk("rst_out_en", out_en, 0);
        chk("rst_out_len", out_len, 0);
        chk("rst_hdr_err", hdr_err, 0);
        chk("rst_flit_cnt", flit_cnt, 0);
        chk("rst_in_ready", in_ready, 1);

        for (int i = 0; i < 8; i++) begin
            run_vec(tbl[i], 0);
        end

        // Reset in the middle of a 4-beat flit.
        @(negedge clk);
        in_valid = 1'b1; in_data = 16'h0004;
        @(negedge clk);
        in_data = 16'h1111;
        @(negedge clk);
        in_data = 16'h2222;
        @(negedge clk);
        in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cnt_exp = 16'h0;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_flit_cnt", flit_cnt, 0);
        chk("midrst_out_flit", out_flit, 0);
        v_tmp = mk(16'h0002, 128'hEEEE_EEEE_EEEE_EEEE_EEEE_EEEE_5555_AAAA, 2, 8'd32,
                   128'h5555_AAAA, 1'b0);
        run_vec(v_tmp, 0);

        // Backpressure with the next (zero-length) header already waiting.
        v_tmp = mk(16'h0003, 128'hEEEE_EEEE_EEEE_EEEE_EEEE_7777_8888_9999, 3, 8'd48,
                   128'h7777_8888_9999, 1'b0);
        run_vec(v_tmp, 10);
        @(negedge clk);
        chk("bp_next_hdr_valid", out_valid, 1);
        chk("bp_next_hdr_len", out_len, 0);
        chk("bp_next_hdr_flit", out_flit, 0);
        in_valid = 1'b0;
        @(negedge clk);
        cnt_exp = cnt_exp + 16'd1;
        chk("bp_next_cnt", flit_cnt, cnt_exp);
        chk("bp_next_done", out_valid, 0);

        // Counter wrap: preload near the top instead of pushing 65k flits.
        force dut.cnt_q = 16'hFFFE;
        #1;
        release dut.cnt_q;
        cnt_exp = 16'hFFFE;
        @(negedge clk);
        chk("wrap_preload", flit_cnt, 16'hFFFE);
        run_vec(tbl[2], 0);
        run_vec(tbl[2], 0);
        chk("wrap_zero", flit_cnt, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
